// File: rtl/signed_div_seq.sv
// rtl/signed_div_seq.sv - sequential signed fixed-point divider (restoring, constant latency)
// One operation in flight: IDLE accepts, ITER runs WIDTH+FRAC_BITS steps, FIX signs/saturates, DONE presents.
module signed_div_seq #(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             div_zero,
  output logic             overflow
);

  localparam int NW = WIDTH + FRAC_BITS;
  localparam int CW = $clog2(NW + 1);

  localparam logic [WIDTH-1:0] MAX_Q   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_Q   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [NW-1:0]    POS_LIM = {{(FRAC_BITS+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [NW-1:0]    NEG_LIM = POS_LIM + NW'(1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NW-1:0]    num_q, num_d;
  logic [NW-1:0]    quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             div_zero_q, div_zero_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    num_d      = num_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvsr_d     = dvsr_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    dz_d       = dz_q;
    quotient_d = quotient_q;
    div_zero_d = div_zero_q;
    overflow_d = overflow_q;

    // magnitudes are unsigned, so the most negative operand maps to 2^(WIDTH-1)
    abs_a  = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
    abs_b  = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;
    rem_sh = (rem_q << 1) | {{WIDTH{1'b0}}, num_q[NW-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    q_bit  = ~trial[WIDTH];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sa_d    = dividend[WIDTH-1];
          sb_d    = divisor[WIDTH-1];
          num_d   = NW'(abs_a) << FRAC_BITS;
          dvsr_d  = abs_b;
          dz_d    = (divisor == '0);
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        num_d = num_q << 1;
        rem_d = q_bit ? trial : rem_sh;
        quo_d = (quo_q << 1) | NW'(q_bit);
        if (cnt_q == CW'(NW - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIX: begin
        // the iteration always runs, so a zero divisor costs the same latency
        if (dz_q) begin
          quotient_d = sa_q ? MIN_Q : MAX_Q;
          div_zero_d = 1'b1;
          overflow_d = 1'b0;
        end else if (sa_q ^ sb_q) begin
          div_zero_d = 1'b0;
          overflow_d = (quo_q > NEG_LIM);
          quotient_d = (quo_q > NEG_LIM) ? MIN_Q : (WIDTH'(0) - quo_q[WIDTH-1:0]);
        end else begin
          div_zero_d = 1'b0;
          overflow_d = (quo_q > POS_LIM);
          quotient_d = (quo_q > POS_LIM) ? MAX_Q : quo_q[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      num_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      dvsr_q     <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      dz_q       <= 1'b0;
      quotient_q <= '0;
      div_zero_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvsr_q     <= dvsr_d;
      sa_q       <= sa_d;
      sb_q       <= sb_d;
      dz_q       <= dz_d;
      quotient_q <= quotient_d;
      div_zero_q <= div_zero_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = quotient_q;
  assign div_zero  = div_zero_q;
  assign overflow  = overflow_q;

endmodule
